// File: rtl/conv_stream_loader_pkg.sv
// Shared configuration for the convolution stream loader: field widths,
// word-counter width and the controller state encoding.
package conv_stream_loader_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int TENSOR_SIZE      = 8;
  localparam int KERNEL_SIZE      = 4;
  localparam int CHANNELS_SIZE    = 8;
  localparam int KERNEL_NUMS_SIZE = 8;
  localparam int CNT_W            = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    LOAD_W = 3'd2,
    LOAD_I = 3'd3,
    LAUNCH = 3'd4,
    RUN    = 3'd5
  } state_t;

endpackage

// File: rtl/conv_stream_loader_stream_len_gate.sv
// Beat counter shared by the weight and ifmap loads: flags the final beat
// of the current segment and classifies s_last as early or missing.
module stream_len_gate
  import conv_stream_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             final_phase,
  input  logic             beat,
  input  logic             s_last,
  input  logic [CNT_W-1:0] len,
  output logic             is_last,
  output logic             final_beat,
  output logic             early_last,
  output logic             missing_last
);

  logic [CNT_W-1:0] cnt_reg;

  assign is_last    = active && (cnt_reg == len - CNT_W'(1));
  assign final_beat = beat && is_last;
  // s_last is only legal on the final beat of the final (ifmap) segment.
  assign early_last   = beat && s_last && !(final_phase && is_last);
  assign missing_last = beat && final_phase && is_last && !s_last;

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      cnt_reg <= '0;
    end else if (beat) begin
      cnt_reg <= is_last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_stream_loader.sv
// Splits one weights-then-ifmap AXI-Stream into the two buffer write streams
// and launches the accelerator once both loads complete.
module conv_stream_loader
  import conv_stream_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [TENSOR_SIZE-1:0]      cfg_tensor_size,
  input  logic [KERNEL_SIZE-1:0]      cfg_kernel_size,
  input  logic [CHANNELS_SIZE-1:0]    cfg_channels,
  input  logic [KERNEL_NUMS_SIZE-1:0] cfg_kernel_nums,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [DATA_WIDTH-1:0]       weight_w_data,
  output logic                        weight_w_valid,
  output logic                        weight_w_last,
  input  logic                        weight_w_ready,
  output logic [DATA_WIDTH-1:0]       ifmap_w_data,
  output logic                        ifmap_w_valid,
  output logic                        ifmap_w_last,
  input  logic                        ifmap_w_ready,
  output logic                        conv_en,
  input  logic                        w_done,
  output logic                        busy,
  output logic                        err_len
);

  state_t                      state_reg, state_next;
  logic                        calc_step_reg;
  logic [TENSOR_SIZE-1:0]      t_reg;
  logic [KERNEL_SIZE-1:0]      k_reg;
  logic [CHANNELS_SIZE-1:0]    c_reg;
  logic [KERNEL_NUMS_SIZE-1:0] n_reg;
  logic [CNT_W-1:0]            kk_reg, tt_reg, nw_reg, ni_reg;
  logic [CNT_W-1:0]            nw_next, ni_next, len;
  logic                        err_len_reg;
  logic                        in_w, in_i, beat;
  logic                        is_last, final_beat, early_last, missing_last;

  assign nw_next = kk_reg * CNT_W'(c_reg) * CNT_W'(n_reg);
  assign ni_next = tt_reg * CNT_W'(c_reg);

  assign in_w = (state_reg == LOAD_W);
  assign in_i = (state_reg == LOAD_I);
  assign len  = in_i ? ni_reg : nw_reg;

  // Zero-latency pass-through: upstream sees the selected buffer's ready.
  assign s_ready        = (in_w && weight_w_ready) || (in_i && ifmap_w_ready);
  assign beat           = s_valid && s_ready;
  assign weight_w_data  = s_data;
  assign ifmap_w_data   = s_data;
  assign weight_w_valid = in_w && s_valid;
  assign ifmap_w_valid  = in_i && s_valid;
  assign weight_w_last  = in_w && is_last;
  assign ifmap_w_last   = in_i && is_last;
  assign busy           = (state_reg != IDLE);
  assign err_len        = err_len_reg;

  stream_len_gate u_gate (
    .clk          (clk),
    .rst          (rst),
    .active       (in_w || in_i),
    .final_phase  (in_i),
    .beat         (beat),
    .s_last       (s_last),
    .len          (len),
    .is_last      (is_last),
    .final_beat   (final_beat),
    .early_last   (early_last),
    .missing_last (missing_last)
  );

  always_comb begin
    state_next = state_reg;
    conv_en    = 1'b0;
    case (state_reg)
      IDLE:   if (start) state_next = CALC;
      CALC: begin
        if (calc_step_reg) begin
          state_next = (nw_next == '0 || ni_next == '0) ? IDLE : LOAD_W;
        end
      end
      LOAD_W: begin
        if (early_last)      state_next = IDLE;
        else if (final_beat) state_next = LOAD_I;
      end
      LOAD_I: begin
        if (early_last)      state_next = IDLE;
        else if (final_beat) state_next = LAUNCH;
      end
      LAUNCH: begin
        conv_en    = 1'b1;
        state_next = RUN;
      end
      RUN:     if (w_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      calc_step_reg <= 1'b0;
      t_reg         <= '0;
      k_reg         <= '0;
      c_reg         <= '0;
      n_reg         <= '0;
      kk_reg        <= '0;
      tt_reg        <= '0;
      nw_reg        <= '0;
      ni_reg        <= '0;
      err_len_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            t_reg         <= cfg_tensor_size;
            k_reg         <= cfg_kernel_size;
            c_reg         <= cfg_channels;
            n_reg         <= cfg_kernel_nums;
            err_len_reg   <= 1'b0;
            calc_step_reg <= 1'b0;
          end
        end
        CALC: begin
          if (!calc_step_reg) begin
            kk_reg        <= CNT_W'(k_reg) * CNT_W'(k_reg);
            tt_reg        <= CNT_W'(t_reg) * CNT_W'(t_reg);
            calc_step_reg <= 1'b1;
          end else begin
            nw_reg        <= nw_next;
            ni_reg        <= ni_next;
            calc_step_reg <= 1'b0;
            if (nw_next == '0 || ni_next == '0) err_len_reg <= 1'b1;
          end
        end
        LOAD_W, LOAD_I: begin
          if (early_last || missing_last) err_len_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_loader.sv
// Scoreboard bench: stimulus pushes expected buffer beats, a negedge monitor
// pops and compares every accepted beat and tracks conv_en pulses.
module tb_conv_stream_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_tensor_size = '0;
  logic [3:0] cfg_kernel_size = '0;
  logic [7:0] cfg_channels = '0;
  logic [7:0] cfg_kernel_nums = '0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] weight_w_data, ifmap_w_data;
  logic       weight_w_valid, weight_w_last, ifmap_w_valid, ifmap_w_last;
  logic       weight_w_ready = 1'b1;
  logic       ifmap_w_ready = 1'b1;
  logic       conv_en, busy, err_len;
  logic       w_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_i_cyc = -10;
  int conv_cnt = 0;
  logic [8:0] weight_q[$];
  logic [8:0] ifmap_q[$];
  logic [7:0] words[$];

  always #5 clk = ~clk;

  conv_stream_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_tensor_size(cfg_tensor_size), .cfg_kernel_size(cfg_kernel_size),
    .cfg_channels(cfg_channels), .cfg_kernel_nums(cfg_kernel_nums),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .weight_w_data(weight_w_data), .weight_w_valid(weight_w_valid),
    .weight_w_last(weight_w_last), .weight_w_ready(weight_w_ready),
    .ifmap_w_data(ifmap_w_data), .ifmap_w_valid(ifmap_w_valid),
    .ifmap_w_last(ifmap_w_last), .ifmap_w_ready(ifmap_w_ready),
    .conv_en(conv_en), .w_done(w_done), .busy(busy), .err_len(err_len)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&ready here.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (!rst) begin
      if (weight_w_valid) begin
        if (weight_q.size() == 0) check("unexpected_weight_valid", 1, 0);
        else if (weight_w_ready) begin
          e = weight_q.pop_front();
          check("weight_beat", {weight_w_last, weight_w_data}, e);
        end
      end
      if (ifmap_w_valid) begin
        if (ifmap_q.size() == 0) check("unexpected_ifmap_valid", 1, 0);
        else if (ifmap_w_ready) begin
          e = ifmap_q.pop_front();
          check("ifmap_beat", {ifmap_w_last, ifmap_w_data}, e);
          if (e[8]) last_i_cyc = cyc;
        end
      end
      if (weight_w_valid && ifmap_w_valid) check("both_valid", 1, 0);
      if (conv_en) begin
        conv_cnt++;
        check("conv_en_latency", cyc, last_i_cyc + 1);
        check("busy_with_conv_en", busy, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_stream(input int n, input int l, input int stall, input int abort_at,
                              output bit aborted);
    int idx = 0;
    int cycles = 0;
    aborted = 0;
    while (idx < n && cycles < 4000) begin
      tick();
      if (abort_at > 0 && idx == abort_at) begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_valids", {weight_w_valid, ifmap_w_valid}, 0);
        check("rst_busy", busy, 0);
        check("rst_conv_en_err", {conv_en, err_len}, 0);
        rst = 1'b0;
        aborted = 1;
        return;
      end
      s_valid = (stall == 0) || ($urandom_range(99) >= stall);
      s_data = words[idx];
      s_last = (idx + 1 == l);
      weight_w_ready = (stall == 0) || ($urandom_range(99) >= stall);
      ifmap_w_ready  = (stall == 0) || ($urandom_range(99) >= stall);
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      cycles++;
    end
    if (idx < n) check("stream_timeout", idx, n);
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
    weight_w_ready = 1'b1;
    ifmap_w_ready = 1'b1;
  endtask

  task automatic spurious_done();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (weight_w_valid) begin
        w_done = 1'b1;
        tick();
        w_done = 1'b0;
        return;
      end
    end
  endtask

  // l: 1-based beat carrying s_last (0 = none).
  task automatic run_case(input int t, input int k, input int c, input int n, input int l,
                          input int stall, input int abort_at, input bit extra);
    int nw = k * k * c * n;
    int ni = t * t * c;
    int total = nw + ni;
    bit zero = (nw == 0) || (ni == 0);
    int n_drive = zero ? 0 : ((l > 0 && l < total) ? l : total);
    bit exp_conv = !zero && (n_drive == total) && (abort_at == 0);
    bit exp_err = zero || (l != total);
    bit aborted;
    int bc;
    logic [7:0] w;
    words.delete();
    for (int i = 0; i < n_drive; i++) begin
      w = 8'($urandom_range(255));
      words.push_back(w);
      if (i < nw) weight_q.push_back({i == nw - 1, w});
      else        ifmap_q.push_back({i - nw == ni - 1, w});
    end
    conv_cnt = 0;
    cfg_tensor_size = 8'(t);
    cfg_kernel_size = 4'(k);
    cfg_channels = 8'(c);
    cfg_kernel_nums = 8'(n);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_tensor_size = 8'($urandom_range(255));
    cfg_channels = 8'($urandom_range(255));
    check("err_cleared_on_start", err_len, 0);
    if (zero) begin
      bc = 0;
      while (busy && bc < 20) begin
        bc++;
        tick();
      end
      // CALC plus at most one decision cycle
      checks++;
      if (bc < 2 || bc > 3) begin
        errors++;
        $display("FAIL zero_len_busy_cycles actual=%0d expected=2..3", bc);
      end
    end else begin
      fork
        drive_stream(n_drive, l, stall, abort_at, aborted);
        if (extra) spurious_done();
      join
      if (aborted) begin
        weight_q.delete();
        ifmap_q.delete();
        return;
      end
    end
    if (exp_conv) begin
      for (int i = 0; i < 20 && conv_cnt == 0; i++) tick();
      if (extra) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      repeat (3) tick();
      check("busy_in_run", busy, 1);
      w_done = 1'b1;
      tick();
      w_done = 1'b0;
      check("busy_after_w_done", busy, 0);
      repeat (2) tick();
    end else begin
      repeat (3) tick();
    end
    check("busy_idle", busy, 0);
    check("err_len", err_len, exp_err);
    check("conv_en_count", conv_cnt, exp_conv);
    check("weight_q_empty", weight_q.size(), 0);
    check("ifmap_q_empty", ifmap_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", {s_ready, weight_w_valid, weight_w_last, ifmap_w_valid,
                            ifmap_w_last, conv_en, busy, err_len}, 0);
    rst = 1'b0;
    tick();
    run_case(4, 3, 1, 2, 34, 0, 0, 0);   // nominal
    run_case(4, 3, 1, 2, 34, 50, 0, 0);  // random back-pressure
    run_case(4, 3, 1, 2, 10, 0, 0, 0);   // early s_last in weights
    run_case(4, 3, 0, 2, 34, 0, 0, 0);   // zero channels
    run_case(4, 3, 1, 2, 34, 0, 25, 0);  // reset mid ifmap load
    run_case(4, 3, 1, 2, 34, 0, 0, 0);
    run_case(4, 3, 1, 2, 34, 0, 0, 1);   // ignored start and w_done
    run_case(4, 3, 1, 2, 0, 0, 0, 0);    // missing final s_last
    run_case(2, 2, 1, 1, 4, 0, 0, 0);    // s_last on final weight beat
    for (int r = 0; r < 6; r++) begin
      int t = $urandom_range(1, 4);
      int k = $urandom_range(1, 3);
      int c = $urandom_range(1, 2);
      int n = $urandom_range(1, 2);
      int tot = k * k * c * n + t * t * c;
      int l = ($urandom_range(2) == 0) ? $urandom_range(1, tot) : tot;
      run_case(t, k, c, n, l, 30, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
